// File: rtl/peripheral_dbg_soc_ring_router_demux.sv
// peripheral_dbg_soc_ring_router_demux: steers DII worms from the ring to the local port or the next hop
// Output registers drain independently; only the target register gates acceptance.
package dii_pkg;
    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit_t;
endpackage

module peripheral_dbg_soc_ring_router_demux #(
    parameter logic [15:0] ID = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  dii_pkg::dii_flit_t in_ring,
    output logic              in_ring_ready,
    output dii_pkg::dii_flit_t out_local,
    input  logic              out_local_ready,
    output dii_pkg::dii_flit_t out_ring,
    input  logic              out_ring_ready
);
    typedef enum logic [1:0] {IDLE, WORM_LOCAL, WORM_RING} state_t;
    state_t state, state_next;
    logic tgt_local, xfer, load_local, load_ring;
    always_comb begin
        // Data is only decoded as a destination on a header; worm states keep their target.
        tgt_local     = (state == IDLE) ? (in_ring.data == ID) : (state == WORM_LOCAL);
        in_ring_ready = !rst & (tgt_local ? (!out_local.valid | out_local_ready)
                                          : (!out_ring.valid | out_ring_ready));
        xfer          = in_ring.valid & in_ring_ready;
        load_local    = xfer & tgt_local;
        load_ring     = xfer & !tgt_local;
        state_next    = state;
        if (xfer)
            state_next = in_ring.last ? IDLE
                       : (state != IDLE) ? state
                       : tgt_local ? WORM_LOCAL : WORM_RING;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_local <= '0;
            out_ring  <= '0;
        end else begin
            state <= state_next;
            if (load_local)
                out_local <= '{valid: 1'b1, last: in_ring.last, data: in_ring.data};
            else if (out_local_ready)
                out_local.valid <= 1'b0;
            if (load_ring)
                out_ring <= '{valid: 1'b1, last: in_ring.last, data: in_ring.data};
            else if (out_ring_ready)
                out_ring.valid <= 1'b0;
        end
    end
endmodule
